// File: rtl/henad_pkg.sv
// Shared constants for the Henad pipeline: stage indices, default datapath
// widths and the instruction-set tag selected out of reset.
package henad_pkg;

  localparam int STG_IA = 0;
  localparam int STG_IF = 1;
  localparam int STG_ID = 2;
  localparam int STG_EX = 3;
  localparam int STG_MA = 4;
  localparam int STG_MO = 5;
  localparam int STG_RA = 6;
  localparam int STG_RO = 7;

  localparam int NUM_STG = STG_RO + 1;

  localparam int DEF_ADDR_W  = 12;
  localparam int DEF_INSTR_W = 12;
  localparam int DEF_SET_W   = 4;

  localparam logic [DEF_SET_W-1:0] ISET_BASE = '0;

endpackage

// File: rtl/pipe_sequencer_if.sv
// Bundle between the pipeline sequencer (master), the instruction memory and
// the per-stage control blocks (slave side).
interface pipe_sequencer_if
  import henad_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int SET_W   = DEF_SET_W,
  parameter int STAGES  = NUM_STG
);

  // Flow control has no valid/ready pair: stall_req[k] high means slot k
  // cannot advance this cycle; the sequencer freezes k and every slot
  // upstream of it and inserts a bubble just downstream of the frozen group.
  logic [ADDR_W-1:0]         mem_addr;
  logic                      mem_en;
  logic [INSTR_W-1:0]        mem_data;
  logic [STAGES-1:0]         stall_req;
  logic                      redirect_valid;
  logic [ADDR_W-1:0]         redirect_pc;
  logic                      set_wr;
  logic [SET_W-1:0]          set_val;
  logic [STAGES-1:0]         stage_valid;
  logic [STAGES*ADDR_W-1:0]  stage_pc;
  logic [STAGES*INSTR_W-1:0] stage_instr;
  logic [STAGES*SET_W-1:0]   stage_set;
  logic                      retire_valid;
  logic [31:0]               retire_count;

  modport master (
    output mem_addr, mem_en,
    input  mem_data,
    input  stall_req, redirect_valid, redirect_pc, set_wr, set_val,
    output stage_valid, stage_pc, stage_instr, stage_set,
    output retire_valid, retire_count
  );

  modport slave (
    input  mem_addr, mem_en,
    output mem_data,
    output stall_req, redirect_valid, redirect_pc, set_wr, set_val,
    input  stage_valid, stage_pc, stage_instr, stage_set,
    input  retire_valid, retire_count
  );

endinterface

// File: rtl/pipe_stage_reg.sv
// One pipeline slot: valid/pc/instr/set register with flush, hold and bubble
// controls (priority in that order); payload is kept when the slot empties.
module pipe_stage_reg
  import henad_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int SET_W   = DEF_SET_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hold_i,
  input  logic               bubble_i,
  input  logic               flush_i,
  input  logic               valid_i,
  input  logic [ADDR_W-1:0]  pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [SET_W-1:0]   set_i,
  output logic               valid_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [SET_W-1:0]   set_o
);

  logic               valid_q, valid_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [SET_W-1:0]   set_q, set_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    set_d   = set_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (!hold_i) begin
      if (bubble_i) begin
        valid_d = 1'b0;
      end else begin
        valid_d = valid_i;
        pc_d    = pc_i;
        instr_d = instr_i;
        set_d   = set_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
      set_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      set_q   <= set_d;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign set_o   = set_q;

endmodule

// File: rtl/pipe_sequencer.sv
// Pipeline sequencer: fetch address generation plus valid/pc/instr/set slots
// with per-slot stall, branch-redirect flush, set switching and retire count.
module pipe_sequencer
  import henad_pkg::*;
#(
  parameter int                  ADDR_W      = DEF_ADDR_W,
  parameter int                  INSTR_W     = DEF_INSTR_W,
  parameter int                  SET_W       = DEF_SET_W,
  parameter int                  STAGES      = NUM_STG,
  parameter int                  REDIR_STAGE = STG_EX,
  parameter logic [ADDR_W-1:0]   RESET_PC    = '0,
  parameter logic [SET_W-1:0]    SET_BASE    = SET_W'(ISET_BASE)
) (
  input logic              clk,
  input logic              rst,
  pipe_sequencer_if.master bus
);

  logic [STAGES-1:0] freeze;
  logic              redir_take;

  logic               slot_v     [STAGES];
  logic [ADDR_W-1:0]  slot_pc    [STAGES];
  logic [INSTR_W-1:0] slot_instr [STAGES];
  logic [SET_W-1:0]   slot_set   [STAGES];

  logic              v0_q, v0_d;
  logic [ADDR_W-1:0] pc0_q, pc0_d;
  logic              v1_q, v1_d;
  logic [ADDR_W-1:0] pc1_q, pc1_d;
  logic [SET_W-1:0]  cur_set_q, cur_set_d;
  logic [31:0]       retire_cnt_q, retire_cnt_d;
  logic              retire_now;

  // A stall at slot j freezes j and everything upstream of it.
  always_comb begin
    freeze = '0;
    for (int k = 0; k < STAGES; k++) begin
      freeze[k] = |(bus.stall_req >> k);
    end
  end

  assign redir_take = bus.redirect_valid & slot_v[REDIR_STAGE] & ~freeze[REDIR_STAGE];
  assign retire_now = slot_v[STAGES-1] & ~bus.stall_req[STAGES-1];

  always_comb begin
    v0_d         = 1'b1;
    pc0_d        = pc0_q;
    v1_d         = v1_q;
    pc1_d        = pc1_q;
    cur_set_d    = bus.set_wr ? bus.set_val : cur_set_q;
    retire_cnt_d = retire_now ? retire_cnt_q + 32'd1 : retire_cnt_q;

    // The first valid edge only marks slot 0 valid; counting starts after.
    if (redir_take) begin
      pc0_d = bus.redirect_pc;
    end else if (v0_q && !freeze[0]) begin
      pc0_d = pc0_q + ADDR_W'(1);
    end

    if (redir_take) begin
      v1_d = 1'b0;
    end else if (!freeze[1]) begin
      if (freeze[0]) begin
        v1_d = 1'b0;
      end else begin
        v1_d  = v0_q;
        pc1_d = pc0_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q         <= 1'b0;
      pc0_q        <= RESET_PC;
      v1_q         <= 1'b0;
      pc1_q        <= '0;
      cur_set_q    <= SET_BASE;
      retire_cnt_q <= '0;
    end else begin
      v0_q         <= v0_d;
      pc0_q        <= pc0_d;
      v1_q         <= v1_d;
      pc1_q        <= pc1_d;
      cur_set_q    <= cur_set_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // Slot 1's instruction is the registered memory output itself; the
  // instruction set is attached when slot 2 captures it.
  assign slot_v[0]     = v0_q;
  assign slot_pc[0]    = pc0_q;
  assign slot_instr[0] = '0;
  assign slot_set[0]   = cur_set_q;
  assign slot_v[1]     = v1_q;
  assign slot_pc[1]    = pc1_q;
  assign slot_instr[1] = bus.mem_data;
  assign slot_set[1]   = cur_set_q;

  for (genvar k = 2; k < STAGES; k++) begin : g_slot
    localparam bit IN_FLUSH = (k <= REDIR_STAGE);

    pipe_stage_reg #(
      .ADDR_W  (ADDR_W),
      .INSTR_W (INSTR_W),
      .SET_W   (SET_W)
    ) u_reg (
      .clk      (clk),
      .rst      (rst),
      .hold_i   (freeze[k]),
      .bubble_i (freeze[k-1]),
      .flush_i  (redir_take & IN_FLUSH),
      .valid_i  (slot_v[k-1]),
      .pc_i     (slot_pc[k-1]),
      .instr_i  (slot_instr[k-1]),
      .set_i    (slot_set[k-1]),
      .valid_o  (slot_v[k]),
      .pc_o     (slot_pc[k]),
      .instr_o  (slot_instr[k]),
      .set_o    (slot_set[k])
    );
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_pack
    assign bus.stage_valid[k]                    = slot_v[k];
    assign bus.stage_pc[k*ADDR_W +: ADDR_W]      = slot_pc[k];
    assign bus.stage_instr[k*INSTR_W +: INSTR_W] = slot_instr[k];
    assign bus.stage_set[k*SET_W +: SET_W]       = slot_set[k];
  end

  assign bus.mem_addr     = pc0_q;
  assign bus.mem_en       = ~freeze[0];
  assign bus.retire_valid = retire_now;
  assign bus.retire_count = retire_cnt_q;

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed bench for pipe_sequencer: free run, stall, redirect, set switch,
// PC wrap and mid-stream reset, with a retire-order scoreboard.
module tb_pipe_sequencer;

  localparam int S  = 8;
  localparam int AW = 12;
  localparam int IW = 12;
  localparam int SW = 4;
  localparam logic [IW-1:0] XK = 12'hA5A;

  logic clk;
  logic rst0;
  logic rst1;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_q[$];

  pipe_sequencer_if #(.ADDR_W(AW), .INSTR_W(IW), .SET_W(SW), .STAGES(S)) bus0 ();
  pipe_sequencer_if #(.ADDR_W(AW), .INSTR_W(IW), .SET_W(SW), .STAGES(S)) bus1 ();

  pipe_sequencer #(
    .ADDR_W(AW), .INSTR_W(IW), .SET_W(SW), .STAGES(S),
    .REDIR_STAGE(3), .RESET_PC(12'h000), .SET_BASE(4'h0)
  ) u_dut0 (
    .clk (clk),
    .rst (rst0),
    .bus (bus0)
  );

  pipe_sequencer #(
    .ADDR_W(AW), .INSTR_W(IW), .SET_W(SW), .STAGES(S),
    .REDIR_STAGE(3), .RESET_PC(12'hFFE), .SET_BASE(4'h0)
  ) u_dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // registered instruction memories: data = addr ^ 12'hA5A
  always @(posedge clk) if (bus0.mem_en) bus0.mem_data <= bus0.mem_addr ^ XK;
  always @(posedge clk) if (bus1.mem_en) bus1.mem_data <= bus1.mem_addr ^ XK;

  function automatic logic [AW-1:0] pc0(input int k);
    return bus0.stage_pc[k*AW +: AW];
  endfunction
  function automatic logic [IW-1:0] in0(input int k);
    return bus0.stage_instr[k*IW +: IW];
  endfunction
  function automatic logic [SW-1:0] st0(input int k);
    return bus0.stage_set[k*SW +: SW];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_run(input logic [AW-1:0] start, input int n, input logic [SW-1:0] s);
    for (int i = 0; i < n; i++) exp_q.push_back({s, start + AW'(i)});
  endtask

  // driver: settle inputs, score a retirement of dut0 if one happens this
  // cycle, then advance one edge and sample 1 time unit after it
  task automatic tick();
    logic [31:0] want;
    #1;
    if (bus0.retire_valid === 1'b1) begin
      if (exp_q.size() > 0) want = {16'h0, exp_q.pop_front()};
      else want = 32'hDEAD_BEEF;
      chk("retire_set_pc", {16'h0, st0(S-1), pc0(S-1)}, want);
      chk("retire_instr", {20'h0, in0(S-1)}, {20'h0, want[AW-1:0] ^ XK});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle0();
    bus0.stall_req = '0; bus0.redirect_valid = 1'b0; bus0.redirect_pc = '0;
    bus0.set_wr = 1'b0; bus0.set_val = '0;
  endtask

  task automatic idle1();
    bus1.stall_req = '0; bus1.redirect_valid = 1'b0; bus1.redirect_pc = '0;
    bus1.set_wr = 1'b0; bus1.set_val = '0;
  endtask

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    idle0();
    idle1();

    // ---- reset, then free run
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_valid", {24'h0, bus0.stage_valid}, 32'h0);
    chk("rst_pc0", {20'h0, pc0(0)}, 32'h0);
    chk("rst_pc7", {20'h0, pc0(7)}, 32'h0);
    chk("rst_instr7", {20'h0, in0(7)}, 32'h0);
    chk("rst_set", {28'h0, st0(0)}, 32'h0);
    chk("rst_count", bus0.retire_count, 32'h0);

    push_run(12'h000, 41, 4'h0);
    rst0 = 1'b0;
    tick();                                   // E0
    chk("e0_valid", {24'h0, bus0.stage_valid}, 32'h01);
    chk("e0_pc0", {20'h0, pc0(0)}, 32'h0);
    tick();                                   // E1
    chk("e1_valid", {24'h0, bus0.stage_valid}, 32'h03);
    chk("e1_pc1", {20'h0, pc0(1)}, 32'h0);
    chk("e1_instr1", {20'h0, in0(1)}, 32'hA5A);
    chk("e1_mem_addr", {20'h0, bus0.mem_addr}, 32'h1);
    repeat (6) tick();                        // E7
    chk("e7_valid", {24'h0, bus0.stage_valid}, 32'hFF);
    chk("e7_pc7", {20'h0, pc0(7)}, 32'h0);
    chk("e7_instr7", {20'h0, in0(7)}, 32'hA5A);
    chk("e7_set7", {28'h0, st0(7)}, 32'h0);
    #1 chk("e7_retire_valid", {31'h0, bus0.retire_valid}, 32'h1);
    repeat (9) tick();                        // E16
    chk("e16_count", bus0.retire_count, 32'd9);
    tick();                                   // E17
    chk("e17_count", bus0.retire_count, 32'd10);

    // ---- stall slot 4 for three cycles
    bus0.stall_req = 8'h10;
    #1 chk("stall_mem_en_c1", {31'h0, bus0.mem_en}, 32'h0);
    tick();                                   // E18
    chk("stall_valid_e18", {24'h0, bus0.stage_valid}, 32'hDF);
    chk("stall_mem_en_c2", {31'h0, bus0.mem_en}, 32'h0);
    tick();                                   // E19
    chk("stall_mem_en_c3", {31'h0, bus0.mem_en}, 32'h0);
    tick();                                   // E20
    chk("stall_valid_e20", {24'h0, bus0.stage_valid}, 32'h1F);
    chk("stall_pc0_held", {20'h0, pc0(0)}, 32'd17);
    chk("stall_pc4_held", {20'h0, pc0(4)}, 32'd13);
    chk("stall_count", bus0.retire_count, 32'd13);
    bus0.stall_req = '0;
    #1 chk("stall_release_mem_en", {31'h0, bus0.mem_en}, 32'h1);
    repeat (12) tick();                       // E32
    chk("post_stall_count", bus0.retire_count, 32'd22);

    // ---- mid-stream reset, set switch at E5, redirect at E9
    rst0 = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    chk("rst2_valid", {24'h0, bus0.stage_valid}, 32'h0);
    chk("rst2_count", bus0.retire_count, 32'h0);
    chk("rst2_pc0", {20'h0, pc0(0)}, 32'h0);
    push_run(12'h000, 4, 4'h0);
    push_run(12'h004, 2, 4'h2);
    push_run(12'h100, 64, 4'h5);
    rst0 = 1'b0;
    repeat (5) tick();                        // E4
    bus0.set_wr = 1'b1; bus0.set_val = 4'h2;
    tick();                                   // E5
    bus0.set_wr = 1'b0;
    chk("set_e5_pc2", {20'h0, pc0(2)}, 32'd3);
    chk("set_e5_old_set", {28'h0, st0(2)}, 32'h0);
    chk("set_e5_cur_set", {28'h0, st0(0)}, 32'h2);
    tick();                                   // E6
    chk("set_e6_pc2", {20'h0, pc0(2)}, 32'd4);
    chk("set_e6_new_set", {28'h0, st0(2)}, 32'h2);
    repeat (2) tick();                        // E8
    chk("redir_pre_pc3", {20'h0, pc0(3)}, 32'd5);
    bus0.redirect_valid = 1'b1; bus0.redirect_pc = 12'h100;
    bus0.set_wr = 1'b1; bus0.set_val = 4'h5;
    tick();                                   // E9
    idle0();
    chk("redir_valid", {24'h0, bus0.stage_valid}, 32'hF1);
    chk("redir_pc0", {20'h0, pc0(0)}, 32'h100);
    chk("redir_pc4", {20'h0, pc0(4)}, 32'd5);
    chk("redir_set", {28'h0, st0(0)}, 32'h5);
    chk("redir_mem_addr", {20'h0, bus0.mem_addr}, 32'h100);
    tick();                                   // E10
    chk("redir_e10_valid", {24'h0, bus0.stage_valid}, 32'hE3);
    chk("redir_e10_pc1", {20'h0, pc0(1)}, 32'h100);
    chk("redir_e10_instr1", {20'h0, in0(1)}, 32'hB5A);
    repeat (7) tick();                        // E17
    chk("redir_e17_pc7", {20'h0, pc0(7)}, 32'h101);
    chk("redir_e17_count", bus0.retire_count, 32'd7);

    // ---- redirect while slot 3 is frozen is ignored
    bus0.stall_req = 8'h20;
    bus0.redirect_valid = 1'b1; bus0.redirect_pc = 12'h200;
    tick();                                   // E18
    idle0();
    chk("frz_redir_pc0", {20'h0, pc0(0)}, 32'h108);
    chk("frz_redir_valid", {24'h0, bus0.stage_valid}, 32'hBF);
    repeat (12) tick();                       // E30
    chk("frz_redir_count", bus0.retire_count, 32'd19);

    // ---- PC wrap and mid-stream reset on the RESET_PC = FFE instance
    rst1 = 1'b0;
    tick();                                   // dut1 E0
    chk("wrap_e0_valid", {24'h0, bus1.stage_valid}, 32'h01);
    chk("wrap_e0_pc0", {20'h0, bus1.stage_pc[0 +: AW]}, 32'hFFE);
    repeat (7) tick();                        // dut1 E7
    chk("wrap_r0_pc", {20'h0, bus1.stage_pc[7*AW +: AW]}, 32'hFFE);
    chk("wrap_r0_instr", {20'h0, bus1.stage_instr[7*IW +: IW]}, 32'h5A4);
    chk("wrap_r0_rv", {31'h0, bus1.retire_valid}, 32'h1);
    tick();                                   // dut1 E8
    chk("wrap_r1_pc", {20'h0, bus1.stage_pc[7*AW +: AW]}, 32'hFFF);
    chk("wrap_r1_instr", {20'h0, bus1.stage_instr[7*IW +: IW]}, 32'h5A5);
    tick();                                   // dut1 E9
    chk("wrap_r2_pc", {20'h0, bus1.stage_pc[7*AW +: AW]}, 32'h000);
    chk("wrap_r2_instr", {20'h0, bus1.stage_instr[7*IW +: IW]}, 32'hA5A);
    chk("wrap_count", bus1.retire_count, 32'd2);
    rst1 = 1'b1;
    bus1.redirect_valid = 1'b1; bus1.redirect_pc = 12'h123;
    bus1.set_wr = 1'b1; bus1.set_val = 4'h7;
    tick();
    idle1();
    chk("rst3_valid", {24'h0, bus1.stage_valid}, 32'h0);
    chk("rst3_count", bus1.retire_count, 32'h0);
    chk("rst3_pc0", {20'h0, bus1.stage_pc[0 +: AW]}, 32'hFFE);
    chk("rst3_set", {28'h0, bus1.stage_set[0 +: SW]}, 32'h0);
    chk("rst3_mem_addr", {20'h0, bus1.mem_addr}, 32'hFFE);
    rst1 = 1'b0;
    tick();
    chk("rst3_e0_valid", {24'h0, bus1.stage_valid}, 32'h01);
    chk("rst3_e0_pc0", {20'h0, bus1.stage_pc[0 +: AW]}, 32'hFFE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
